// File: rtl/mqst_frame_rx.sv
// Sync-hunting, length-prefixed frame receiver with checksum-gated payload FIFO.
// Optional inter-byte timeout is built only when MQST_RX_TIMEOUT_EN is defined.
module mqst_frame_rx #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         FIFO_DEPTH  = 32,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_in_valid,
  output logic [7:0]                    pay_data,
  output logic                          pay_valid,
  input  logic                          pay_ready,
  output logic                          frame_ok,
  output logic                          frame_err,
  output logic [1:0]                    err_code,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {HUNT = 2'd0, LEN = 2'd1, PAYLOAD = 2'd2, CSUM = 2'd3} state_t;

  state_t         state_r, state_n_s;
  logic [PW-1:0]  wr_spec_r, wr_spec_n_s, wr_commit_r, wr_commit_n_s, rd_ptr_r;
  logic [7:0]     sum_r, sum_n_s, cnt_r, cnt_n_s;
  logic           frame_ok_r, frame_ok_n_s, frame_err_r, frame_err_n_s;
  logic [1:0]     err_code_r, err_code_n_s;
  logic           we_s, pay_valid_s, timeout_s;
  logic [PW-1:0]  fifo_level_s;
  logic [8:0]     space_s;
  logic [7:0]     mem_r [FIFO_DEPTH];

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign fifo_level_s = wr_commit_r - rd_ptr_r;
  assign pay_valid_s  = (wr_commit_r != rd_ptr_r);
  assign space_s      = 9'(FIFO_DEPTH) - 9'(fifo_level_s);

`ifdef MQST_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_r;

  // Inter-byte idle counter, active only while a frame is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (byte_in_valid || (state_r == HUNT) || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  assign timeout_s = (state_r != HUNT) && !byte_in_valid && (to_cnt_r == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Parser next-state, speculative write and commit/rewind decisions
  always_comb begin
    state_n_s     = state_r;
    wr_spec_n_s   = wr_spec_r;
    wr_commit_n_s = wr_commit_r;
    sum_n_s       = sum_r;
    cnt_n_s       = cnt_r;
    frame_ok_n_s  = 1'b0;
    frame_err_n_s = 1'b0;
    err_code_n_s  = err_code_r;
    we_s          = 1'b0;
    if (timeout_s) begin
      wr_spec_n_s   = wr_commit_r;
      frame_err_n_s = 1'b1;
      err_code_n_s  = 2'd0;
      state_n_s     = HUNT;
    end else if (byte_in_valid) begin
      case (state_r)
        HUNT: begin
          if (byte_in == SYNC_BYTE) begin
            state_n_s = LEN;
          end else begin
            state_n_s = HUNT;
          end
        end
        LEN: begin
          // Space check uses the registered level; a same-cycle read is not credited
          if (byte_in > 8'(MAX_LEN)) begin
            frame_err_n_s = 1'b1;
            err_code_n_s  = 2'd1;
            state_n_s     = HUNT;
          end else if ({1'b0, byte_in} > space_s) begin
            frame_err_n_s = 1'b1;
            err_code_n_s  = 2'd2;
            state_n_s     = HUNT;
          end else if (byte_in == 8'd0) begin
            sum_n_s   = 8'd0;
            cnt_n_s   = 8'd0;
            state_n_s = CSUM;
          end else begin
            sum_n_s   = byte_in;
            cnt_n_s   = byte_in;
            state_n_s = PAYLOAD;
          end
        end
        PAYLOAD: begin
          we_s        = 1'b1;
          wr_spec_n_s = wr_spec_r + PW'(1);
          sum_n_s     = csum_add(sum_r, byte_in);
          cnt_n_s     = cnt_r - 8'd1;
          if (cnt_r == 8'd1) begin
            state_n_s = CSUM;
          end else begin
            state_n_s = PAYLOAD;
          end
        end
        CSUM: begin
          if (csum_add(sum_r, byte_in) == 8'd0) begin
            wr_commit_n_s = wr_spec_r;
            frame_ok_n_s  = 1'b1;
          end else begin
            wr_spec_n_s   = wr_commit_r;
            frame_err_n_s = 1'b1;
            err_code_n_s  = 2'd3;
          end
          state_n_s = HUNT;
        end
        default: state_n_s = HUNT;
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Parser, pointer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      wr_spec_r   <= '0;
      wr_commit_r <= '0;
      rd_ptr_r    <= '0;
      sum_r       <= 8'd0;
      cnt_r       <= 8'd0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      err_code_r  <= 2'd0;
    end else begin
      state_r     <= state_n_s;
      wr_spec_r   <= wr_spec_n_s;
      wr_commit_r <= wr_commit_n_s;
      sum_r       <= sum_n_s;
      cnt_r       <= cnt_n_s;
      frame_ok_r  <= frame_ok_n_s;
      frame_err_r <= frame_err_n_s;
      err_code_r  <= err_code_n_s;
      if (pay_valid_s && pay_ready) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Payload storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_spec_r[AW-1:0]] <= byte_in;
    end
  end

  assign pay_data   = mem_r[rd_ptr_r[AW-1:0]];
  assign pay_valid  = pay_valid_s;
  assign frame_ok   = frame_ok_r;
  assign frame_err  = frame_err_r;
  assign err_code   = err_code_r;
  assign rx_busy    = (state_r != HUNT);
  assign fifo_level = fifo_level_s;

endmodule

// File: tb/tb_mqst_frame_rx.sv
// Directed bench for mqst_frame_rx: frame table plus multi-cycle FIFO/reset sequences.
module tb_mqst_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_in_valid;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_busy;
  logic [5:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  logic [7:0] got_q[$];

  mqst_frame_rx dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_in_valid(byte_in_valid),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .rx_busy(rx_busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          exp_ok;
    int          exp_err;
    logic [1:0]  exp_code;
    logic [31:0] pay;
    int          pn;
  } vec_t;

  vec_t tbl[8];

  // Pulse counters and delivered-byte capture, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (pay_valid && pay_ready) got_q.push_back(pay_data);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_in_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [63:0] b, input int n, input int ok,
                         input int er, input logic [1:0] code, input logic [31:0] p, input int pn);
    tbl[i].bytes = b; tbl[i].n = n; tbl[i].exp_ok = ok; tbl[i].exp_err = er;
    tbl[i].exp_code = code; tbl[i].pay = p; tbl[i].pn = pn;
  endtask

  logic [7:0] csum;
  logic [7:0] exp_b;

  initial begin
    set_vec(0, 64'h00FFA50311223397, 8, 1, 0, 2'd0, 32'h00112233, 3);
    set_vec(1, 64'h0000A50311223398, 6, 0, 1, 2'd3, 32'h0, 0);
    set_vec(2, 64'h000000000000A511, 2, 0, 1, 2'd1, 32'h0, 0);
    set_vec(3, 64'h0000000000A50000, 3, 1, 0, 2'd1, 32'h0, 0);
    set_vec(4, 64'h00000000A5015AA5, 4, 1, 0, 2'd1, 32'h0000005A, 1);
    set_vec(5, 64'h000000A502A5A5B4, 5, 1, 0, 2'd1, 32'h0000A5A5, 2);
    set_vec(6, 64'h000000000022A5A5, 3, 0, 1, 2'd1, 32'h0, 0);
    set_vec(7, 64'h000000A5021234B8, 5, 1, 0, 2'd1, 32'h00001234, 2);

    rst_n = 1'b0; byte_in = 8'd0; byte_in_valid = 1'b0; pay_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_pay_valid", pay_valid, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_rx_busy", rx_busy, 0);
    chk("rst_fifo_level", fifo_level, 0);

    // Table of single frames with the consumer always ready
    pay_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      ok_cnt = 0; err_cnt = 0; got_q.delete();
      for (int k = 0; k < tbl[v].n; k++) send(tbl[v].bytes[8*(tbl[v].n-1-k) +: 8]);
      chk($sformatf("v%0d_ok_latency", v), frame_ok, tbl[v].exp_ok);
      chk($sformatf("v%0d_err_latency", v), frame_err, tbl[v].exp_err);
      idle(5);
      chk($sformatf("v%0d_ok_cnt", v), ok_cnt, tbl[v].exp_ok);
      chk($sformatf("v%0d_err_cnt", v), err_cnt, tbl[v].exp_err);
      chk($sformatf("v%0d_err_code", v), err_code, tbl[v].exp_code);
      chk($sformatf("v%0d_busy", v), rx_busy, 0);
      chk($sformatf("v%0d_level", v), fifo_level, 0);
      chk($sformatf("v%0d_pay_n", v), got_q.size(), tbl[v].pn);
      for (int k = 0; k < tbl[v].pn && k < got_q.size(); k++)
        chk($sformatf("v%0d_pay%0d", v, k), got_q[k], tbl[v].pay[8*(tbl[v].pn-1-k) +: 8]);
    end

    // Fill FIFO to capacity with two maximum-length frames
    pay_ready = 1'b0; ok_cnt = 0; err_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      csum = 8'd16;
      send(8'hA5); send(8'd16);
      for (int i = 0; i < 16; i++) begin
        send(8'(f*16 + i + 1));
        csum = csum + 8'(f*16 + i + 1);
      end
      send(8'd0 - csum);
      chk($sformatf("fill%0d_ok", f), frame_ok, 1);
      chk($sformatf("fill%0d_level", f), fifo_level, 16*(f+1));
    end
    chk("fill_head", pay_data, 8'd1);
    chk("fill_valid", pay_valid, 1);
    // No space: the read in the LEN cycle must not be credited
    send(8'hA5);
    pay_ready = 1'b1;
    send(8'h01);
    chk("nospace_err", frame_err, 1);
    chk("nospace_code", err_code, 2);
    chk("nospace_level", fifo_level, 31);
    for (int i = 1; i < 32; i++) begin
      chk($sformatf("drain%0d_valid", i), pay_valid, 1);
      chk($sformatf("drain%0d_data", i), pay_data, i + 1);
      @(posedge clk); #1;
    end
    chk("drain_empty", pay_valid, 0);
    chk("drain_level", fifo_level, 0);
    chk("fill_ok_cnt", ok_cnt, 2);

    // Commit and read in the same cycle
    pay_ready = 1'b0; got_q.delete();
    send(8'hA5); send(8'h01); send(8'h5A); send(8'hA5);
    chk("sim_level1", fifo_level, 1);
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
    pay_ready = 1'b1;
    send(8'hCB);
    chk("sim_ok", frame_ok, 1);
    chk("sim_level", fifo_level, 2);
    idle(4);
    chk("sim_n", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("sim_b0", got_q[0], 8'h5A);
      chk("sim_b1", got_q[1], 8'h11);
      chk("sim_b2", got_q[2], 8'h22);
    end

    // Stalled frame, then reset with committed data held in the FIFO
    pay_ready = 1'b0; err_cnt = 0;
    send(8'hA5); send(8'h01); send(8'h5A); send(8'hA5);
    send(8'hA5); send(8'h02); send(8'h11);
`ifdef MQST_RX_TIMEOUT_EN
    for (int c = 0; c < 4200 && err_cnt == 0; c++) idle(1);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_code", err_code, 0);
    chk("to_busy", rx_busy, 0);
`else
    idle(4200);
    chk("noto_err_cnt", err_cnt, 0);
    chk("noto_busy", rx_busy, 1);
`endif
    chk("stall_level", fifo_level, 1);
    send(8'hA5); send(8'h03); send(8'h11);
    rst_n = 1'b0;
    #1;
    chk("mrst_pay_valid", pay_valid, 0);
    chk("mrst_level", fifo_level, 0);
    chk("mrst_busy", rx_busy, 0);
    chk("mrst_ok", frame_ok, 0);
    chk("mrst_err", frame_err, 0);
    chk("mrst_code", err_code, 0);
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    ok_cnt = 0; err_cnt = 0; got_q.delete(); pay_ready = 1'b1;
    chk("post_rst_err", err_cnt, 0);
    send(8'hA5); send(8'h01); send(8'h5A); send(8'hA5);
    chk("post_rst_ok", frame_ok, 1);
    idle(3);
    chk("post_rst_n", got_q.size(), 1);
    if (got_q.size() == 1) chk("post_rst_b0", got_q[0], 8'h5A);
    chk("post_rst_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
